// File: rtl/key_uart_tx.sv
// key_uart_tx: sends the 4-byte report "K<hh>\n" over 8N1 UART for each new key press,
// then returns a one-cycle done pulse on fd to release the key stage.
module key_uart_tx #(
   parameter int unsigned CLK_FREQ = 50_000_000,
   parameter int unsigned BAUD     = 115200
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       fs,
   output logic       fd,
   output logic       tx,
   output logic       busy,
   output logic [7:0] cnt
);
   localparam int unsigned BAUD_DIV  = CLK_FREQ / BAUD;
   localparam int unsigned BIT_CNT_W = 16;
   localparam logic [BIT_CNT_W-1:0] BIT_LAST = BIT_CNT_W'(BAUD_DIV - 1);

   typedef enum logic [2:0] {
      S_IDLE, S_LOAD, S_START, S_DATA, S_STOP, S_DONE
   } state_t;

   state_t               state;
   logic                 fs_last;
   logic [BIT_CNT_W-1:0] bit_cnt;
   logic [2:0]           bit_idx;
   logic [1:0]           byte_idx;
   logic [7:0]           shift;
   logic                 bit_end;

   assign bit_end = (bit_cnt == BIT_LAST);

   function automatic logic [7:0] hex_char(input logic [3:0] n);
      return (n < 4'd10) ? (8'h30 + {4'h0, n}) : (8'h37 + {4'h0, n});
   endfunction

   function automatic logic [7:0] report_byte(input logic [1:0] idx, input logic [7:0] c);
      case (idx)
         2'd0:    return 8'h4B;
         2'd1:    return hex_char(c[7:4]);
         2'd2:    return hex_char(c[3:0]);
         default: return 8'h0A;
      endcase
   endfunction

   // Outputs are registered from the current state, so tx trails the state by one cycle.
   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= S_IDLE;
         fs_last  <= 1'b0;
         bit_cnt  <= '0;
         bit_idx  <= '0;
         byte_idx <= '0;
         shift    <= '0;
         cnt      <= '0;
         tx       <= 1'b1;
         fd       <= 1'b0;
         busy     <= 1'b0;
      end else begin
         fs_last <= fs;
         fd      <= 1'b0;
         case (state)
            S_IDLE: begin
               tx   <= 1'b1;
               busy <= 1'b0;
               if (fs && !fs_last) begin
                  cnt      <= cnt + 8'd1;
                  byte_idx <= '0;
                  state    <= S_LOAD;
               end
            end
            S_LOAD: begin
               tx      <= 1'b1;
               busy    <= 1'b1;
               shift   <= report_byte(byte_idx, cnt);
               bit_cnt <= '0;
               bit_idx <= '0;
               state   <= S_START;
            end
            S_START: begin
               tx      <= 1'b0;
               bit_cnt <= bit_end ? '0 : bit_cnt + BIT_CNT_W'(1);
               if (bit_end) state <= S_DATA;
            end
            S_DATA: begin
               tx      <= shift[0];
               bit_cnt <= bit_end ? '0 : bit_cnt + BIT_CNT_W'(1);
               if (bit_end) begin
                  shift <= {1'b0, shift[7:1]};
                  if (bit_idx == 3'd7) state <= S_STOP;
                  else bit_idx <= bit_idx + 3'd1;
               end
            end
            S_STOP: begin
               tx      <= 1'b1;
               bit_cnt <= bit_end ? '0 : bit_cnt + BIT_CNT_W'(1);
               if (bit_end) begin
                  if (byte_idx != 2'd3) begin
                     byte_idx <= byte_idx + 2'd1;
                     state    <= S_LOAD;
                  end else begin
                     state <= S_DONE;
                  end
               end
            end
            S_DONE: begin
               tx    <= 1'b1;
               fd    <= 1'b1;
               busy  <= 1'b1;
               state <= S_IDLE;
            end
            default: state <= S_IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_key_uart_tx.sv
// Bench for key_uart_tx: a slow instance (BAUD_DIV=10) for timing/corner cases and a fast
// instance (BAUD_DIV=2) for the 256-press counter wrap; tx is decoded as a UART receiver would.
module tb_key_uart_tx;
   localparam int unsigned CF     = 1000;
   localparam int unsigned BAUD_S = 100;
   localparam int unsigned BAUD_F = 500;
   localparam int unsigned BD_S   = CF / BAUD_S;
   localparam int unsigned BD_F   = CF / BAUD_F;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic fs0, fs1, fd0, fd1, tx0, tx1, busy0, busy1;
   logic [7:0] cnt0, cnt1;

   int unsigned cyc = 0;
   int unsigned fs_until [2] = '{0, 0};
   bit          fs_hold  [2] = '{1'b0, 1'b0};

   logic       txa [2], fda [2], busya [2];
   logic [7:0] cnta [2];

   // receiver / monitor state (written only by the monitor process)
   bit          rx_on  [2] = '{1'b0, 1'b0};
   int          rx_t   [2] = '{0, 0};
   logic [7:0]  rx_sh  [2];
   bit          fd_prev[2] = '{1'b0, 1'b0};
   int unsigned fd_n   [2] = '{0, 0};
   int unsigned viol   [2] = '{0, 0};
   logic [7:0]  q0 [$];
   logic [7:0]  q1 [$];

   // bench bookkeeping (written only by the main process)
   int unsigned rd      [2] = '{0, 0};
   logic [7:0]  exp_cnt [2] = '{8'h00, 8'h00};
   int unsigned n_pass = 0;
   int unsigned n_chk  = 0;

   typedef struct {
      int unsigned press;
      logic [7:0]  b1;
      logic [7:0]  b2;
      logic [7:0]  c;
   } vec_t;
   vec_t tbl [4];

   always #5 clk = ~clk;

   assign fs0 = fs_hold[0] || (cyc < fs_until[0]);
   assign fs1 = fs_hold[1] || (cyc < fs_until[1]);

   always_comb begin
      txa[0] = tx0;   txa[1] = tx1;
      fda[0] = fd0;   fda[1] = fd1;
      busya[0] = busy0; busya[1] = busy1;
      cnta[0] = cnt0; cnta[1] = cnt1;
   end

   key_uart_tx #(.CLK_FREQ(CF), .BAUD(BAUD_S)) dut (
      .clk(clk), .rst(rst), .fs(fs0), .fd(fd0), .tx(tx0), .busy(busy0), .cnt(cnt0)
   );

   key_uart_tx #(.CLK_FREQ(CF), .BAUD(BAUD_F)) dut_fast (
      .clk(clk), .rst(rst), .fs(fs1), .fd(fd1), .tx(tx1), .busy(busy1), .cnt(cnt1)
   );

   function automatic int bdv(input int i);
      return (i == 0) ? int'(BD_S) : int'(BD_F);
   endfunction

   function automatic int unsigned qsize(input int i);
      return (i == 0) ? unsigned'(q0.size()) : unsigned'(q1.size());
   endfunction

   function automatic logic [7:0] qget(input int i, input int unsigned k);
      if (i == 0) return (k < unsigned'(q0.size())) ? q0[k] : 8'hxx;
      return (k < unsigned'(q1.size())) ? q1[k] : 8'hxx;
   endfunction

   // Reference: report = 'K', uppercase hex of the count, LF.
   function automatic logic [7:0] exp_byte(input logic [7:0] c, input int k);
      string hx;
      hx = "0123456789ABCDEF";
      case (k)
         0:       return 8'h4B;
         1:       return hx[int'(c) / 16];
         2:       return hx[int'(c) % 16];
         default: return 8'h0A;
      endcase
   endfunction

   always @(negedge clk) begin
      cyc++;
      for (int i = 0; i < 2; i++) begin
         if (rst) begin
            rx_on[i] = 1'b0;
         end else if (!rx_on[i]) begin
            if (txa[i] === 1'b0) begin
               rx_on[i] = 1'b1;
               rx_t[i]  = 0;
            end
         end else begin
            rx_t[i]++;
            if (rx_t[i] == 9 * bdv(i) + bdv(i) / 2) begin
               if (txa[i] !== 1'b1) viol[i]++;
               if (i == 0) q0.push_back(rx_sh[i]);
               else q1.push_back(rx_sh[i]);
               rx_on[i] = 1'b0;
            end else if (rx_t[i] > bdv(i) && (rx_t[i] % bdv(i)) == bdv(i) / 2) begin
               rx_sh[i] = {txa[i], rx_sh[i][7:1]};
            end
         end
         if (fda[i] === 1'b1) begin
            fd_n[i]++;
            if (fd_prev[i] || busya[i] !== 1'b1) viol[i]++;
         end
         fd_prev[i] = (fda[i] === 1'b1);
      end
   end

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      else n_pass++;
   endtask

   task automatic tick(input int n);
      repeat (n) @(negedge clk);
      #1;
   endtask

   // One press of fs for len cycles; checks the decoded report, fd and cnt.
   task automatic run_frame(input int i, input int len, output logic [31:0] got,
                            output int unsigned ts, output int unsigned tf);
      int unsigned f0, rd0, t;
      f0  = fd_n[i];
      rd0 = rd[i];
      tick(1);
      fs_until[i] = cyc + unsigned'(len);
      exp_cnt[i]  = exp_cnt[i] + 8'd1;
      t = 0; ts = 0;
      while (fd_n[i] == f0 && t < unsigned'(50 * bdv(i) + 200)) begin
         tick(1);
         t++;
         if (ts == 0 && txa[i] === 1'b0) ts = t;
      end
      tf = t;
      tick(4);
      chk("fd_count", 32'(fd_n[i] - f0), 32'd1);
      chk("busy_after", 32'(busya[i]), 32'd0);
      for (int k = 0; k < 4; k++) begin
         got[8*k +: 8] = qget(i, rd0 + unsigned'(k));
         chk($sformatf("byte%0d_cnt%0h", k, exp_cnt[i]), 32'(got[8*k +: 8]),
             32'(exp_byte(exp_cnt[i], k)));
      end
      rd[i] = rd0 + 4;
      chk("cnt", 32'(cnta[i]), 32'(exp_cnt[i]));
   endtask

   initial begin
      logic [31:0] got;
      int unsigned ts, tf, f0, rd0, t, bad;

      tbl[0] = '{1,   8'h30, 8'h31, 8'h01};
      tbl[1] = '{10,  8'h30, 8'h41, 8'h0A};
      tbl[2] = '{255, 8'h46, 8'h46, 8'hFF};
      tbl[3] = '{256, 8'h30, 8'h30, 8'h00};

      // reset and idle
      tick(3);
      chk("rst_tx", 32'(tx0), 32'd1);
      chk("rst_fd", 32'(fd0), 32'd0);
      chk("rst_busy", 32'(busy0), 32'd0);
      chk("rst_cnt", 32'(cnt0), 32'd0);
      rst = 1'b0;
      bad = 0;
      for (int c = 0; c < 100; c++) begin
         tick(1);
         if (tx0 !== 1'b1 || fd0 !== 1'b0 || busy0 !== 1'b0 || cnt0 !== 8'h00) bad++;
      end
      chk("idle_stable", bad, 0);

      // first press: latency to start bit and start-bit-to-fd span (inclusive of fd cycle)
      run_frame(0, 5, got, ts, tf);
      chk("start_latency", ts, 3);
      chk("frame_span", tf - ts + 1, 40 * BD_S + 4);

      // fs held high: exactly one frame
      f0 = fd_n[0]; rd0 = rd[0];
      tick(1);
      fs_hold[0] = 1'b1;
      exp_cnt[0] = exp_cnt[0] + 8'd1;
      tick(2000);
      fs_hold[0] = 1'b0;
      tick(20);
      chk("hold_fd", fd_n[0] - f0, 1);
      chk("hold_bytes", qsize(0) - rd0, 4);
      for (int k = 0; k < 4; k++)
         chk($sformatf("hold_byte%0d", k), 32'(qget(0, rd0 + unsigned'(k))), 32'(exp_byte(exp_cnt[0], k)));
      rd[0] = rd0 + 4;
      chk("hold_cnt", 32'(cnt0), 32'(exp_cnt[0]));

      // random press lengths
      for (int n = 0; n < 2; n++) begin
         run_frame(0, int'($urandom_range(1, 40)), got, ts, tf);
         tick(int'($urandom_range(0, 6)));
      end

      // fast instance: 256 presses with random pulse widths and gaps, wrap checked by table
      for (int p = 1; p <= 256; p++) begin
         run_frame(1, int'($urandom_range(1, 30)), got, ts, tf);
         for (int v = 0; v < 4; v++) begin
            if (tbl[v].press == unsigned'(p)) begin
               chk($sformatf("tbl_p%0d_b1", p), 32'(got[15:8]), 32'(tbl[v].b1));
               chk($sformatf("tbl_p%0d_b2", p), 32'(got[23:16]), 32'(tbl[v].b2));
               chk($sformatf("tbl_p%0d_cnt", p), 32'(cnt1), 32'(tbl[v].c));
            end
         end
         tick(int'($urandom_range(0, 5)));
      end

      // reset in the middle of byte 2
      f0 = fd_n[0];
      tick(1);
      fs_until[0] = cyc + 4;
      t = 0;
      while (qsize(0) < rd[0] + 2 && t < 2000) begin tick(1); t++; end
      chk("abort_reach_byte2", 32'(qsize(0) >= rd[0] + 2), 32'd1);
      tick(3 * BD_S);
      rst = 1'b1;
      tick(1);
      rst = 1'b0;
      exp_cnt[0] = 8'h00;
      exp_cnt[1] = 8'h00;
      chk("abort_tx", 32'(tx0), 32'd1);
      chk("abort_busy", 32'(busy0), 32'd0);
      chk("abort_cnt", 32'(cnt0), 32'd0);
      chk("abort_cnt_fast", 32'(cnt1), 32'd0);
      bad = 0;
      for (int c = 0; c < 500; c++) begin
         tick(1);
         if (tx0 !== 1'b1 || fd0 !== 1'b0 || busy0 !== 1'b0) bad++;
      end
      chk("abort_quiet", bad, 0);
      chk("abort_no_fd", fd_n[0] - f0, 0);
      rd[0] = qsize(0);
      run_frame(0, 6, got, ts, tf);

      // fs drops mid-frame, rises again while busy: one frame, edge ignored
      f0 = fd_n[0]; rd0 = rd[0];
      tick(1);
      fs_until[0] = cyc + 3;
      exp_cnt[0] = exp_cnt[0] + 8'd1;
      tick(100);
      chk("mid_busy", 32'(busy0), 32'd1);
      fs_until[0] = cyc + 5;
      t = 0;
      while (fd_n[0] == f0 && t < 1000) begin tick(1); t++; end
      tick(500);
      chk("mid_fd", fd_n[0] - f0, 1);
      chk("mid_bytes", qsize(0) - rd0, 4);
      for (int k = 0; k < 4; k++)
         chk($sformatf("mid_byte%0d", k), 32'(qget(0, rd0 + unsigned'(k))), 32'(exp_byte(exp_cnt[0], k)));
      rd[0] = rd0 + 4;
      chk("mid_cnt", 32'(cnt0), 32'(exp_cnt[0]));
      run_frame(0, 5, got, ts, tf);

      chk("monitor_viol_slow", viol[0], 0);
      chk("monitor_viol_fast", viol[1], 0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule

// File: doc/key_uart_tx.md
Name: key_uart_tx

Overview:
Downstream consumer of the debounced key-press handshake (fs/fd). Each new press transmits a 4-byte ASCII report over 8N1 UART: 'K', two uppercase hex digits of a press counter, then LF. When the last stop bit is done, the block returns a one-cycle done pulse on fd, which lets the key stage return to its idle state.

Parameters:
CLK_FREQ, 50_000_000, clk frequency in Hz
BAUD, 115200, UART bit rate; BAUD_DIV = CLK_FREQ/BAUD (integer divide, 434 at defaults), clk cycles per bit

Ports:
clk  input  1  system clock, all logic on posedge
rst  input  1  synchronous reset, active-high
fs   input  1  press-valid level from key stage; held high until fd or key-stage timeout
fd   output 1  done pulse, exactly 1 cycle, after full frame sent
tx   output 1  UART serial line, idle high, registered
busy output 1  high while a frame is in progress (LOAD..DONE)
cnt  output 8  press counter, value last transmitted

Behaviour:
- Reset (rst=1 at posedge):
  - State goes to IDLE; tx=1, fd=0, busy=0, cnt=0x00.
  - All internal counters are cleared.
  - The fs edge-detect register is cleared to 0.
  - Reset during a frame aborts it: tx=1 the cycle after, no fd pulse, cnt keeps 0x00.
- Start condition:
  - Trigger only on an fs rising edge (fs=1 and fs_last=0) while in IDLE.
  - A level held high does not retrigger.
  - An edge seen outside IDLE is ignored.
- States:
  - IDLE: tx=1. On trigger: cnt<=cnt+1 (wraps 0xFF->0x00), byte_idx<=0, go to LOAD.
  - LOAD: (1 cycle) latch shift byte from byte_idx, go to START, busy=1 from here.
  - START: tx=0 for BAUD_DIV cycles, then go to DATA.
  - DATA: send 8 bits LSB-first, each held BAUD_DIV cycles; after bit 7, go to STOP.
  - STOP: tx=1 for BAUD_DIV cycles. If byte_idx<3: byte_idx++ and go to LOAD. Else go to DONE.
  - DONE: (1 cycle) fd=1, busy=1, then go to IDLE.
- Bytes:
  - idx0 = 0x4B 'K'.
  - idx1 = hex(cnt[7:4]).
  - idx2 = hex(cnt[3:0]).
  - idx3 = 0x0A.
  - hex(n) = 0x30+n for n<10, 0x37+n for n>=10 (uppercase A-F).
  - cnt is stable for the whole frame.
- Timing:
  - Start bit of byte 0 begins 2 clk edges after the edge at which the fs rise is sampled.
  - Each byte takes 10*BAUD_DIV cycles, plus 1 LOAD cycle between bytes (tx held 1 there).
  - Total from first start bit to fd = 40*BAUD_DIV + 3 + 1 cycles.
- Bit counter: counts 0..BAUD_DIV-1, wraps to 0 on each bit boundary. Width is sufficient for BAUD_DIV up to 2^16.
- fs drops mid-frame (key-stage timeout): the frame still completes and fd still pulses. The key stage ignores fd when idle.
- fs high again in the cycle right after DONE: fs_last must see the low phase before a new edge counts. A new frame starts only after fs goes low and rises again.
- fd and busy are never high outside DONE / an active frame; fd is never high for 2 consecutive cycles.

Test Plan:
- Reset, then idle 100 cycles -> tx=1, fd=0, busy=0, cnt=0x00 throughout.
- CLK_FREQ=1000, BAUD=100 (BAUD_DIV=10); pulse fs high 5 cycles -> decoded bytes 0x4B,0x30,0x31,0x0A; cnt=0x01; one fd pulse; start-to-fd = 404 cycles.
- Hold fs high continuously for 2000 cycles -> exactly one frame and one fd pulse, no retrigger.
- Issue 255 more presses (256 total) -> 10th press sends "K0A\n" (0x30,0x41), 255th sends "KFF\n", 256th sends "K00\n" with cnt=0x00.
- Assert rst for 1 cycle midway through byte 2 -> tx=1 next cycle, busy=0, no fd, cnt=0x00; next press sends "K01\n".
- Drop fs mid-frame, then raise it again while busy -> current frame completes with one fd; the mid-frame edge is ignored; the next clean press sends the next count.
